// File: rtl/fifo_pkg.sv
// fifo_pkg: shared arbiter state type, burst-counter width helper and Gray/binary conversions for the async FIFO.
package fifo_pkg;
  typedef enum logic [0:0] {ARB, LOCKED} arb_state_e;
  localparam int GW = 16;
  function automatic int bcnt_width(input int maxburst);
    return $clog2(maxburst + 1);
  endfunction
  // Conversions run at a fixed 16-bit width; callers size the result with a cast.
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; the first asserted req at or above ptr (mod N) wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N-1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        gnt = N'(1) << idx;
      end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter with bounded burst lock, write pointer and full flag.
// Optional registered almost-full output wafull when FIFO_WR_AFULL_EN is defined.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ADDRSIZE  = 6,
  parameter int DSIZE     = 8,
  parameter int MAXBURST  = 8,
  parameter int AFULL_LVL = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*DSIZE-1:0] wdata_in,
  input  logic [ADDRSIZE:0]     wq2_rptr,
  output logic [NREQ-1:0]       grant,
  output logic                  wen,
  output logic [ADDRSIZE-1:0]   waddr,
  output logic [DSIZE-1:0]      wdata,
  output logic [ADDRSIZE:0]     wptr,
  output logic                  wfull
`ifdef FIFO_WR_AFULL_EN
  ,
  output logic                  wafull
`endif
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = ADDRSIZE + 1;
  localparam int BW = bcnt_width(MAXBURST);
  arb_state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, pick_idx;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [PW-1:0] wbin_q, wbin_d, wptr_q, wptr_d;
  logic          wfull_q, wfull_d, ready_q;
  logic [NREQ-1:0] elig, pick_gnt;
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (int'(i) == NREQ-1) ? '0 : i + 1'b1;
  endfunction
  // In LOCKED only the owner is eligible, and only while it still holds lock.
  assign elig = (state_q == LOCKED) ? (req & lock & (NREQ'(1) << owner_q)) : req;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req (elig),
    .ptr (rr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );
  always_comb begin
    grant   = (ready_q && !wfull_q) ? pick_gnt : '0;
    wen     = |grant;
    waddr   = wbin_q[ADDRSIZE-1:0];
    wdata   = wdata_in[int'(pick_idx)*DSIZE +: DSIZE];
    wbin_d  = wbin_q + PW'(wen);
    wptr_d  = PW'(bin2gray(GW'(wbin_d)));
    wfull_d = wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wptr    = wptr_q;
    wfull   = wfull_q;
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    rr_d    = rr_q;
    if (state_q == ARB) begin
      if (wen && lock[pick_idx] && MAXBURST > 1) begin
        state_d = LOCKED;
        owner_d = pick_idx;
        bcnt_d  = BW'(1);
      end else if (wen) rr_d = nxt(pick_idx);
    end else if (!wfull_q) begin
      // No owner transfer while not full means req or lock dropped.
      bcnt_d = bcnt_q + BW'(wen);
      if (!wen || bcnt_d == BW'(MAXBURST)) begin
        state_d = ARB;
        rr_d    = nxt(owner_q);
        bcnt_d  = '0;
      end
    end
  end
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      state_q <= ARB;
      owner_q <= '0;
      bcnt_q  <= '0;
      rr_q    <= '0;
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      bcnt_q  <= bcnt_d;
      rr_q    <= rr_d;
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
      ready_q <= 1'b1;
    end
`ifdef FIFO_WR_AFULL_EN
  logic [PW-1:0] used;
  logic [PW:0]   free;
  logic          wafull_q;
  always_comb begin
    used   = wbin_d - PW'(gray2bin(GW'(wq2_rptr)));
    free   = ((PW+1)'(1) << ADDRSIZE) - {1'b0, used};
    wafull = wafull_q;
  end
  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) wafull_q <= 1'b0;
    else         wafull_q <= free <= (PW+1)'(AFULL_LVL);
`endif
endmodule
